// File: rtl/ram_if.sv
// Bus bundle for the single-port word RAM: address, select, operation, write
// data and registered read data. The master drives the access and the slave
// (the RAM) returns read data.

`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

interface ram_if #(
  parameter int word_size   = 20,
  parameter int word_amount = 30
);
  logic [$clog2(word_amount)-1:0] address;
  logic                           select;
  logic                           operation;
  logic [word_size-1:0]           wdata;
  logic [word_size-1:0]           rdata;

  modport master (
    output address,
    output select,
    output operation,
    output wdata,
    input  rdata
  );

  modport slave (
    input  address,
    input  select,
    input  operation,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/ram.sv
// Single-port synchronous word RAM. One access per clock: select=1 with
// operation=1 writes wdata into the addressed word, and select=1 with
// operation=0 loads the addressed word into the registered rdata. Addresses
// at or beyond word_amount are ignored on write and read back as zero.
// Storage is a flop array so the asynchronous reset can clear every word.

module ram #(
  parameter int word_size   = 20,
  parameter int word_amount = 30
) (
  input  logic   clk,
  input  logic   rst_n,
  ram_if.slave   bus
);

  localparam int   addr_w   = $clog2(word_amount);
  localparam logic op_write = 1'b1;

  logic [word_size-1:0] mem_q [word_amount];
  logic [word_size-1:0] mem_d [word_amount];
  logic [word_size-1:0] rdata_q;
  logic [word_size-1:0] rdata_d;
  logic                 wr_en_s;
  logic                 rd_en_s;
  logic [word_size-1:0] rd_word_s;

  assign wr_en_s  = bus.select & (bus.operation == op_write);
  assign rd_en_s  = bus.select & (bus.operation != op_write);
  assign bus.rdata = rdata_q;

  // Read mux: OR of the one word whose index matches; no match (out of range) gives zero
  always_comb begin
    rd_word_s = {word_size{1'b0}};
    for (int i = 0; i < word_amount; i++) begin
      rd_word_s = rd_word_s |
                  ({word_size{bus.address == addr_w'(i)}} & mem_q[i]);
    end
  end

  // Next-state for storage words and the read register
  always_comb begin
    for (int i = 0; i < word_amount; i++) begin
      mem_d[i] = (wr_en_s && (bus.address == addr_w'(i))) ? bus.wdata : mem_q[i];
    end
    if (rd_en_s) begin
      rdata_d = rd_word_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers; reset clears every word and the read data immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < word_amount; i++) begin
        mem_q[i] <= {word_size{1'b0}};
      end
      rdata_q <= {word_size{1'b0}};
    end else begin
      for (int i = 0; i < word_amount; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ram.sv
// Directed bench for the word RAM. Inputs change on the falling edge; rdata is
// sampled on the falling edge after the sampling rising edge.

module tb_ram;

  localparam int ws = 20;
  localparam int wa = 30;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [ws-1:0] exp_mem [wa];

  ram_if #(.word_size(ws), .word_amount(wa)) bus_if ();

  ram #(.word_size(ws), .word_amount(wa)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [ws-1:0] d);
    @(negedge clk);
    bus_if.select    = 1'b1;
    bus_if.operation = 1'b1;
    bus_if.address   = a;
    bus_if.wdata     = d;
  endtask

  task automatic idle();
    @(negedge clk);
    bus_if.select    = 1'b0;
    bus_if.operation = 1'($urandom_range(0, 1));
    bus_if.address   = 5'($urandom_range(0, 31));
    bus_if.wdata     = ws'($urandom);
  endtask

  // read one word and check it on the next falling edge; leaves the bus idle
  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [ws-1:0] e);
    @(negedge clk);
    bus_if.select    = 1'b1;
    bus_if.operation = 1'b0;
    bus_if.address   = a;
    bus_if.wdata     = ws'($urandom);
    @(negedge clk);
    bus_if.select    = 1'b0;
    chk(tag, 32'(bus_if.rdata), 32'(e));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < wa; i++) exp_mem[i] = '0;
    rst_n            = 1'b0;
    bus_if.select    = 1'b0;
    bus_if.operation = 1'b0;
    bus_if.address   = 5'd0;
    bus_if.wdata     = '0;
    #12;
    chk("rst_rdata", 32'(bus_if.rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset state of memory
    rd_chk("rst_a0", 5'd0, 20'd0);
    rd_chk("rst_a2", 5'd2, 20'd0);
    rd_chk("rst_a29", 5'd29, 20'd0);

    // write / idle / read
    wr(5'd2, 20'd17); exp_mem[2] = 20'd17;
    idle();
    rd_chk("wr_rd_a2", 5'd2, 20'd17);

    // hold and isolation
    wr(5'd29, 20'hFFFFF); exp_mem[29] = 20'hFFFFF;
    wr(5'd0, 20'd5);      exp_mem[0]  = 20'd5;
    rd_chk("rd_a29", 5'd29, 20'hFFFFF);
    for (int c = 0; c < 3; c++) begin
      idle();
      chk($sformatf("hold_%0d", c), 32'(bus_if.rdata), 32'hFFFFF);
    end
    rd_chk("rd_a0", 5'd0, 20'd5);

    // out of range: write ignored, reads give zero, nothing else disturbed
    wr(5'd30, 20'd123);
    wr(5'd31, 20'h54321);
    rd_chk("oor_a30", 5'd30, 20'd0);
    rd_chk("rd_a0_b", 5'd0, 20'd5);
    rd_chk("oor_a31", 5'd31, 20'd0);
    for (int i = 0; i < wa; i++) begin
      rd_chk($sformatf("scan_a%0d", i), 5'(i), exp_mem[i]);
    end

    // back-to-back write then read on the very next edge
    wr(5'd3, 20'd7); exp_mem[3] = 20'd7;
    rd_chk("b2b_a3", 5'd3, 20'd7);

    // mid-operation reset
    wr(5'd4, 20'd9);
    @(posedge clk);
    bus_if.select = 1'b0;
    #2;
    chk("pre_rst_rdata", 32'(bus_if.rdata), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata", 32'(bus_if.rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_a4", 5'd4, 20'd0);
    rd_chk("post_rst_a3", 5'd3, 20'd0);
    rd_chk("post_rst_a29", 5'd29, 20'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
